// File: rtl/tri_setup.sv
`timescale 1ns/1ps
// Triangle setup: edge increments, row-wrap increments and tile-origin edge values.
// Latency: rast_start 11 cycles after accept (tri_done in cycle 11 if culled).
// Backpressure: tri_ready only in IDLE; holds until downstream rast_done.
module tri_setup (
    input  logic                clk,
    input  logic                rst,
    input  logic                tri_valid,
    output logic                tri_ready,
    input  logic signed [11:0]  v0x,
    input  logic signed [11:0]  v0y,
    input  logic signed [11:0]  v1x,
    input  logic signed [11:0]  v1y,
    input  logic signed [11:0]  v2x,
    input  logic signed [11:0]  v2y,
    input  logic        [4:0]   tile_x,
    input  logic        [4:0]   tile_y,
    output logic signed [18:0]  A01,
    output logic signed [18:0]  A12,
    output logic signed [18:0]  A20,
    output logic signed [23:0]  B01,
    output logic signed [23:0]  B12,
    output logic signed [23:0]  B20,
    output logic signed [31:0]  w0,
    output logic signed [31:0]  w1,
    output logic signed [31:0]  w2,
    output logic                rast_start,
    input  logic                rast_done,
    output logic                tri_done,
    output logic                tri_culled
);

    typedef enum logic [2:0] {IDLE, DIFF, MUL, NORM, LAUNCH, WAIT, DONE} state_t;

    state_t             r_state;
    logic signed [11:0] r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y;
    logic        [4:0]  r_tx, r_ty;
    logic signed [12:0] r_a01, r_a12, r_a20;
    logic signed [12:0] r_b01, r_b12, r_b20;
    logic signed [12:0] r_px, r_py;
    logic        [2:0]  r_mcnt;
    logic signed [31:0] r_area, r_e12, r_e20, r_e01;
    logic               r_ready, r_start, r_done, r_culled;
    logic signed [18:0] r_A01, r_A12, r_A20;
    logic signed [23:0] r_B01, r_B12, r_B20;
    logic signed [31:0] r_w0, r_w1, r_w2;

    function automatic logic signed [12:0] sx13(input logic signed [11:0] v);
        return {v[11], v};
    endfunction

    function automatic logic signed [13:0] sx14(input logic signed [11:0] v);
        return {{2{v[11]}}, v};
    endfunction

    function automatic logic signed [18:0] sx19(input logic signed [12:0] v);
        return {{6{v[12]}}, v};
    endfunction

    function automatic logic signed [23:0] sx24(input logic signed [12:0] v);
        return {{11{v[12]}}, v};
    endfunction

    // Row-wrap increment before orientation: Braw - 31*A, with 31*A = (A<<5)-A.
    function automatic logic signed [23:0] row_wrap(input logic signed [12:0] braw,
                                                    input logic signed [12:0] a);
        logic signed [23:0] a24;
        a24 = sx24(a);
        return sx24(braw) - ((a24 <<< 5) - a24);
    endfunction

    // Differences feeding the second multiplier operand, all 14-bit signed.
    logic signed [13:0] w_px14, w_py14;
    logic signed [13:0] w_d_v2x_v0x, w_d_v2y_v0y;
    logic signed [13:0] w_d_px_v0x, w_d_py_v0y, w_d_px_v1x, w_d_py_v1y, w_d_px_v2x, w_d_py_v2y;

    assign w_px14      = {1'b0, r_px};
    assign w_py14      = {1'b0, r_py};
    assign w_d_v2x_v0x = sx14(r_v2x) - sx14(r_v0x);
    assign w_d_v2y_v0y = sx14(r_v2y) - sx14(r_v0y);
    assign w_d_px_v0x  = w_px14 - sx14(r_v0x);
    assign w_d_py_v0y  = w_py14 - sx14(r_v0y);
    assign w_d_px_v1x  = w_px14 - sx14(r_v1x);
    assign w_d_py_v1y  = w_py14 - sx14(r_v1y);
    assign w_d_px_v2x  = w_px14 - sx14(r_v2x);
    assign w_d_py_v2y  = w_py14 - sx14(r_v2y);

    logic signed [12:0] w_mul_a;
    logic signed [13:0] w_mul_b;
    logic signed [26:0] w_prod;
    logic signed [31:0] w_prod32;

    // Operand select for the single shared multiplier: two products per accumulator.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_mcnt)
            3'd0: begin w_mul_a = r_a01; w_mul_b = w_d_v2x_v0x; end
            3'd1: begin w_mul_a = r_b01; w_mul_b = w_d_v2y_v0y; end
            3'd2: begin w_mul_a = r_a12; w_mul_b = w_d_px_v1x;  end
            3'd3: begin w_mul_a = r_b12; w_mul_b = w_d_py_v1y;  end
            3'd4: begin w_mul_a = r_a20; w_mul_b = w_d_px_v2x;  end
            3'd5: begin w_mul_a = r_b20; w_mul_b = w_d_py_v2y;  end
            3'd6: begin w_mul_a = r_a01; w_mul_b = w_d_px_v0x;  end
            default: begin w_mul_a = r_b01; w_mul_b = w_d_py_v0y; end
        endcase
    end

    assign w_prod   = {{14{w_mul_a[12]}}, w_mul_a} * {{13{w_mul_b[13]}}, w_mul_b};
    assign w_prod32 = {{5{w_prod[26]}}, w_prod};

    // Vertex bounding box against the tile's pixel range.
    logic signed [11:0] w_max_x, w_min_x, w_max_y, w_min_y;
    logic signed [11:0] w_mx01, w_nx01, w_my01, w_ny01;
    logic signed [13:0] w_px_hi, w_py_hi;
    logic               w_bbox_miss, w_cull, w_neg;

    assign w_mx01  = (r_v0x > r_v1x) ? r_v0x : r_v1x;
    assign w_nx01  = (r_v0x < r_v1x) ? r_v0x : r_v1x;
    assign w_my01  = (r_v0y > r_v1y) ? r_v0y : r_v1y;
    assign w_ny01  = (r_v0y < r_v1y) ? r_v0y : r_v1y;
    assign w_max_x = (w_mx01 > r_v2x) ? w_mx01 : r_v2x;
    assign w_min_x = (w_nx01 < r_v2x) ? w_nx01 : r_v2x;
    assign w_max_y = (w_my01 > r_v2y) ? w_my01 : r_v2y;
    assign w_min_y = (w_ny01 < r_v2y) ? w_ny01 : r_v2y;
    assign w_px_hi = w_px14 + 14'sd31;
    assign w_py_hi = w_py14 + 14'sd31;

    assign w_bbox_miss = (sx14(w_max_x) < w_px14) || (sx14(w_min_x) > w_px_hi) ||
                         (sx14(w_max_y) < w_py14) || (sx14(w_min_y) > w_py_hi);
    assign w_cull      = (r_area == 32'sd0) || w_bbox_miss;
    // Clockwise (negative area) triangles are flipped so inside is always positive.
    assign w_neg       = r_area[31];

    logic signed [18:0] w_a01_19, w_a12_19, w_a20_19;
    logic signed [23:0] w_rw01, w_rw12, w_rw20;

    assign w_a01_19 = sx19(r_a01);
    assign w_a12_19 = sx19(r_a12);
    assign w_a20_19 = sx19(r_a20);
    assign w_rw01   = row_wrap(r_b01, r_a01);
    assign w_rw12   = row_wrap(r_b12, r_a12);
    assign w_rw20   = row_wrap(r_b20, r_a20);

    // Setup sequencer: capture, differences, 8 shared multiplies, cull/normalise, launch, wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_culled <= 1'b0;
            r_v0x <= '0; r_v0y <= '0; r_v1x <= '0; r_v1y <= '0; r_v2x <= '0; r_v2y <= '0;
            r_tx  <= '0; r_ty  <= '0;
            r_a01 <= '0; r_a12 <= '0; r_a20 <= '0;
            r_b01 <= '0; r_b12 <= '0; r_b20 <= '0;
            r_px  <= '0; r_py  <= '0;
            r_mcnt <= '0;
            r_area <= '0; r_e12 <= '0; r_e20 <= '0; r_e01 <= '0;
            r_A01 <= '0; r_A12 <= '0; r_A20 <= '0;
            r_B01 <= '0; r_B12 <= '0; r_B20 <= '0;
            r_w0  <= '0; r_w1  <= '0; r_w2  <= '0;
        end else begin
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_culled <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tri_valid) begin
                        r_v0x <= v0x; r_v0y <= v0y;
                        r_v1x <= v1x; r_v1y <= v1y;
                        r_v2x <= v2x; r_v2y <= v2y;
                        r_tx  <= tile_x;
                        r_ty  <= tile_y;
                        r_ready <= 1'b0;
                        r_state <= DIFF;
                    end
                end
                DIFF: begin
                    r_a01 <= sx13(r_v0y) - sx13(r_v1y);
                    r_a12 <= sx13(r_v1y) - sx13(r_v2y);
                    r_a20 <= sx13(r_v2y) - sx13(r_v0y);
                    r_b01 <= sx13(r_v1x) - sx13(r_v0x);
                    r_b12 <= sx13(r_v2x) - sx13(r_v1x);
                    r_b20 <= sx13(r_v0x) - sx13(r_v2x);
                    r_px  <= {3'b000, r_tx, 5'b00000};
                    r_py  <= {3'b000, r_ty, 5'b00000};
                    r_area <= '0; r_e12 <= '0; r_e20 <= '0; r_e01 <= '0;
                    r_mcnt <= '0;
                    r_state <= MUL;
                end
                MUL: begin
                    case (r_mcnt[2:1])
                        2'd0:    r_area <= r_area + w_prod32;
                        2'd1:    r_e12  <= r_e12  + w_prod32;
                        2'd2:    r_e20  <= r_e20  + w_prod32;
                        default: r_e01  <= r_e01  + w_prod32;
                    endcase
                    r_mcnt <= r_mcnt + 3'd1;
                    if (r_mcnt == 3'd7)
                        r_state <= NORM;
                end
                NORM: begin
                    if (w_cull) begin
                        r_done   <= 1'b1;
                        r_culled <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_A01 <= w_neg ? -w_a01_19 : w_a01_19;
                        r_A12 <= w_neg ? -w_a12_19 : w_a12_19;
                        r_A20 <= w_neg ? -w_a20_19 : w_a20_19;
                        r_B01 <= w_neg ? -w_rw01 : w_rw01;
                        r_B12 <= w_neg ? -w_rw12 : w_rw12;
                        r_B20 <= w_neg ? -w_rw20 : w_rw20;
                        r_w0  <= w_neg ? -r_e12 : r_e12;
                        r_w1  <= w_neg ? -r_e20 : r_e20;
                        r_w2  <= w_neg ? -r_e01 : r_e01;
                        r_start <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (rast_done) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tri_ready  = r_ready;
    assign rast_start = r_start;
    assign tri_done   = r_done;
    assign tri_culled = r_culled;
    assign A01 = r_A01;
    assign A12 = r_A12;
    assign A20 = r_A20;
    assign B01 = r_B01;
    assign B12 = r_B12;
    assign B20 = r_B20;
    assign w0  = r_w0;
    assign w1  = r_w1;
    assign w2  = r_w2;

endmodule

// File: doc/tri_setup.md
TRI_SETUP -- requirements
Module: tri_setup

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the clock, with all state updated on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have tri_valid (input, 1) and tri_ready (output, 1): a triangle is accepted on an edge where both are 1.
REQ-004 SHALL have v0x, v0y, v1x, v1y, v2x, v2y, each an input, signed, 12 bits: integer vertex coordinates in screen space.
REQ-005 SHALL have tile_x and tile_y, each an input, 5 bits: the 32x32 tile index. The tile's top-left pixel is (tile_x*32, tile_y*32).
REQ-006 SHALL have A01, A12 and A20, each an output, signed, 19 bits: the per-column edge increments.
REQ-007 SHALL have B01, B12 and B20, each an output, signed, 24 bits: the row-wrap increments, applied when stepping from X=31 to X=0 of the next row.
REQ-008 SHALL have w0, w1 and w2, each an output, signed, 32 bits: the edge values at the tile's top-left pixel.
REQ-009 SHALL have rast_start (output, 1) and rast_done (input, 1): the downstream 32x32 rasterizer handshake.
REQ-010 SHALL have tri_done (output, 1): a one-cycle completion pulse. It SHALL have tri_culled (output, 1), which is valid only while tri_done=1.

Function
REQ-011 SHALL use a state machine with states IDLE, DIFF, MUL, NORM, LAUNCH, WAIT and DONE; tri_ready=1 only in IDLE.
REQ-012 On accept (IDLE→DIFF), SHALL register all vertex and tile inputs; the inputs are don't-care afterwards.
REQ-013 DIFF (1 cycle) SHALL compute, as 13-bit signed values:
- A01 = v0y−v1y, A12 = v1y−v2y, A20 = v2y−v0y
- Braw01 = v1x−v0x, Braw12 = v2x−v1x, Braw20 = v0x−v2x
- px = tile_x*32, py = tile_y*32
REQ-014 MUL (exactly 8 cycles) SHALL use a single shared signed multiplier, one product per cycle, accumulating with no overflow in 32 bits:
- area = A01*(v2x−v0x) + Braw01*(v2y−v0y)
- e12 = A12*(px−v1x) + Braw12*(py−v1y)
- e20 = A20*(px−v2x) + Braw20*(py−v2y)
- e01 = A01*(px−v0x) + Braw01*(py−v0y)
REQ-015 NORM (1 cycle) SHALL cull the triangle if either condition holds:
- area == 0
- the vertex bounding box misses the tile: max x < px, min x > px+31, max y < py, or min y > py+31
REQ-016 If culled: NORM→DONE with tri_culled=1; rast_start SHALL NOT assert, and the A/B/w outputs keep their previous values.
REQ-017 If not culled, SHALL set s = −1 if area < 0, else +1, and load the outputs:
- Axx = s*Axx (sign-extended to 19 bits)
- Bxx = s*(Brawxx − 31*Axx), with 31*A formed as (A<<5)−A, sign-extended to 24 bits
- w0 = s*e12, w1 = s*e20, w2 = s*e01
REQ-018 LAUNCH SHALL assert rast_start for exactly one cycle, in the 11th cycle after the accepting edge, then go to WAIT.
REQ-019 The A, B and w outputs SHALL be stable from LAUNCH until the next NORM that is not culled.
REQ-020 WAIT SHALL go to DONE on the first edge where rast_done=1; rast_done SHALL be ignored in every other state.
REQ-021 DONE SHALL last 1 cycle with tri_done=1 (and tri_culled=0 on the rasterized path), then go to IDLE.
REQ-022 tri_valid while not in IDLE SHALL be ignored and SHALL NOT be lost; the upstream holds it until tri_ready.

Reset
REQ-023 rst SHALL force IDLE at any time, including mid-MUL or mid-WAIT, with these values:
- tri_ready=1
- rast_start=0, tri_done=0, tri_culled=0
- all A, B and w outputs = 0
- accumulators cleared
REQ-024 After rst deasserts, the first tri_valid SHALL be accepted on the next edge.

Verification
REQ-025 Tile (0,0), v0(0,0), v1(31,0), v2(0,31) → rast_start in cycle 11 with:
- A01=0, A12=−31, A20=31
- B01=31, B12=930, B20=−961
- w0=961, w1=0, w2=0
REQ-026 Tile (0,0), v0(0,0), v1(0,31), v2(31,0) (area −961, so negated) → rast_start with:
- A01=31, A12=−31, A20=0
- B01=−961, B12=930, B20=31
- w0=961, w1=0, w2=0
REQ-027 Collinear v0(0,0), v1(10,10), v2(20,20) → tri_done=1 and tri_culled=1 in cycle 11; rast_start never asserts.
REQ-028 The REQ-025 triangle with tile (1,0) → culled by the bounding-box test; the A/B/w outputs are unchanged from the prior triangle.
REQ-029 Handshake: after LAUNCH, hold rast_done=0 for 1024 cycles then 1, with tri_valid held high throughout →
- tri_done pulses 1 cycle after rast_done is sampled high
- the next triangle is accepted the cycle after DONE
REQ-030 Reset mid-operation: assert rst during MUL cycle 4 → all outputs go to their reset values immediately; no rast_start or tri_done occurs; tri_ready=1.
